inst_axi_rd_bridge: RTL
=======================

# inst_axi_rd_bridge

- Converts the fetch stage's sram-like instruction interface (req / addr_ok / data_ok) into single-beat AXI4 read transactions.
- Sits directly upstream of the fetch stage, between it and the system AXI interconnect.
- Tracks up to `MAX_OUTSTANDING` in-order reads using a single ARID.
- Registers read data so `inst_rdata` stays stable until the next return.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum number of accepted requests still awaiting data (allowed range 1–7).
- `ARID`, default 4'd0: constant ID driven on `arid`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1: fetch request.
- `inst_wr` in 1: write flag; must be 0 (writes are unsupported).
- `inst_size` in 2: log2 of the access size in bytes.
- `inst_addr` in 32: physical fetch address.
- `inst_wdata` in 32: ignored.
- `inst_rdata` out 32: returned instruction word; registered.
- `inst_addr_ok` out 1: request accepted this cycle; combinational.
- `inst_data_ok` out 1: `inst_rdata` is valid this cycle; 1-cycle pulse.
- `inst_data_err` out 1: pulses together with `inst_data_ok` when `rresp` != OKAY.
- `arid` out 4: tied to `ARID`.
- `araddr` out 32: read address.
- `arlen` out 8: tied to 0.
- `arsize` out 3: read size.
- `arburst` out 2: tied to 2'b01.
- `arlock` out 2: tied to 0.
- `arcache` out 4: tied to 0.
- `arprot` out 3: tied to 0.
- `arvalid` out 1: read-address valid.
- `arready` in 1: read-address ready.
- `rid` in 4: read ID; ignored (responses are in order).
- `rdata` in 32: read data.
- `rresp` in 2: read response.
- `rlast` in 1: last beat.
- `rvalid` in 1: read-data valid.
- `rready` out 1: read-data ready.

## Operation
AR channel state machine:
- IDLE: `arvalid`=0.
  - On acceptance: latch `araddr`←`inst_addr` and `arsize`←{1'b0,`inst_size`}, then go to BUSY.
- BUSY: `arvalid`=1, with `araddr` and `arsize` held stable.
  - On `arvalid`&&`arready`: return to IDLE, unless a new request is accepted in the same cycle, in which case reload and stay in BUSY.

Acceptance rule:
- `inst_addr_ok` = `inst_req` && !`inst_wr` && (state==IDLE || `arready`) && (`cnt` < `MAX_OUTSTANDING` || `r_fire`).
- `r_fire` = `rvalid` && `rready` && `rlast` && `cnt`!=0.
- Requests with `inst_wr`=1 are never accepted; `inst_addr_ok` stays 0 while they are held.

Outstanding counter `cnt`:
- Width is clog2(`MAX_OUTSTANDING`+1).
- +1 on `inst_addr_ok`; −1 on `r_fire`; unchanged when both occur in the same cycle.
- Never exceeds `MAX_OUTSTANDING` and never underflows.

R channel:
- `rready` is a register: 0 during reset, 1 from the first cycle after reset deasserts.
- On `r_fire`: `inst_rdata`←`rdata`, and in the next cycle `inst_data_ok`=1 and `inst_data_err`=(`rresp`!=2'b00).
- `inst_rdata` holds its value until the next `r_fire`.
- A beat arriving while `cnt`==0 (stray) is consumed: no `data_ok`, `inst_rdata` unchanged, `cnt` unchanged.

Ordering:
- Data returns in acceptance order.
- Cancellation and discard of stale fetches (exception flush, branch) is done by the consumer, which still receives every `data_ok`.

## Timing
- Reset values: `arvalid`=0, `araddr`=0, `arsize`=0, `cnt`=0, `rready`=0, `inst_rdata`=0, `inst_data_ok`=0, `inst_data_err`=0, state=IDLE.
- Reset asserted mid-transaction clears all state within one cycle. AXI beats still in flight after reset arrive as stray beats and are dropped.
- Request at cycle t with `inst_addr_ok`=1 → `arvalid`=1 from t+1 until the handshake.
- `rvalid` at cycle r → `inst_data_ok` at r+1.
- Minimum request-to-data latency is 3 cycles (addr_ok at t, AR handshake at t+1, rvalid at t+2, data_ok at t+3).
- Sustained throughput is one accepted request per cycle while `arready`=1 and returns keep `cnt` below `MAX_OUTSTANDING`.
- `inst_addr_ok` depends combinationally on `arready`, `rvalid` and `rlast`. No other output is combinational.

## Test plan
- Single fetch:
  - Stimulus: `inst_req` with `addr`=0x1FC00000, `size`=2; slave `arready`=1, then `rvalid` 2 cycles later with `rdata`=0x3C1D0001.
  - Required: `addr_ok` at t; `araddr`=0x1FC00000, `arsize`=3'b010 at t+1; `data_ok` and `rdata`=0x3C1D0001 at t+4; `cnt` back to 0.
- Backpressure:
  - Stimulus: `arready` held 0 for 5 cycles.
  - Required: `arvalid` and `araddr` stable and `inst_addr_ok`=0 throughout; handshake on the first `arready`=1, with a second request accepted in the same cycle.
- Outstanding limit (`MAX_OUTSTANDING`=2):
  - Stimulus: three back-to-back requests, R held off.
  - Required: third `addr_ok`=0 until the first `r_fire`, then accepted in that same cycle with `cnt` staying at 2.
- Error and write rejection:
  - Stimulus: `rresp`=2'b10 on a return; then `inst_req` with `inst_wr`=1.
  - Required: `data_err`=1 together with `data_ok` for the error return; the write request never gets `addr_ok` and causes no AR activity.
- Reset mid-flight:
  - Stimulus: assert `reset` with `cnt`=2 and `arvalid`=1; after deassert, deliver two stale R beats.
  - Required: all outputs at reset values; the stale beats are dropped with no `data_ok`; a new request afterwards completes normally.

Source files
------------

// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for inst_axi_rd_bridge.
//   inst_sram_if : fetch-stage sram-like instruction port (req / addr_ok / data_ok).
//                  master = fetch stage, slave = bridge.
//   axi_rd_if    : AXI4 read-address and read-data channels.
//                  master = bridge, slave = interconnect.

interface inst_sram_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        inst_data_err;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok, inst_data_err
  );
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok, inst_data_err
  );
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side sram-like instruction interface to single-beat AXI4 reads.
// Up to MAX_OUTSTANDING accepted reads may await data; responses return in
// order under a single constant ARID. Read data is registered and held until
// the next return.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   inst   : inst_sram_if.slave  (fetch stage request / data return)
//   axi    : axi_rd_if.master    (AR and R channels to the interconnect)
//
// AR channel states:
//   state | meaning
//   IDLE  | no address pending, arvalid low
//   BUSY  | arvalid high, araddr/arsize held until arready

module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  inst_sram_if.slave  inst,
  axi_rd_if.master    axi
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [2:0]    arsize_q;
  logic          rready_q;
  logic [31:0]   rdata_q;
  logic          data_ok_q;
  logic          data_err_q;

  logic r_fire;
  logic accept;

  // Only a beat matching an outstanding request counts; stray beats (e.g.
  // left over from before a reset) are consumed silently.
  assign r_fire = axi.rvalid && axi.rready && axi.rlast && (cnt != '0);

  // A return in the same cycle frees a slot, so a full bridge can still accept.
  assign accept = inst.inst_req && !inst.inst_wr &&
                  ((state == IDLE) || axi.arready) &&
                  ((cnt < MAX_CNT) || r_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      cnt        <= '0;
      rready_q   <= 1'b0;
      rdata_q    <= '0;
      data_ok_q  <= 1'b0;
      data_err_q <= 1'b0;
    end else begin
      rready_q   <= 1'b1;
      data_ok_q  <= r_fire;
      data_err_q <= r_fire && (axi.rresp != 2'b00);
      if (r_fire) rdata_q <= axi.rdata;

      if (accept && !r_fire)      cnt <= cnt + ONE;
      else if (r_fire && !accept) cnt <= cnt - ONE;

      case (state)
        IDLE: begin
          if (accept) begin
            araddr_q  <= inst.inst_addr;
            arsize_q  <= {1'b0, inst.inst_size};
            arvalid_q <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // accept in BUSY implies arready, i.e. the current address is
          // handshaking and the slot can be reloaded back-to-back.
          if (accept) begin
            araddr_q <= inst.inst_addr;
            arsize_q <= {1'b0, inst.inst_size};
          end else if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign inst.inst_addr_ok  = accept;
  assign inst.inst_rdata    = rdata_q;
  assign inst.inst_data_ok  = data_ok_q;
  assign inst.inst_data_err = data_err_q;

  assign axi.arid    = ARID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Write data and read ID carry no information for an in-order read bridge.
  logic unused_ok;
  assign unused_ok = ^{inst.inst_wdata, axi.rid};

endmodule
